// File: rtl/chunked_mag_comparator.sv
`default_nettype none
// ============================================================================
// Module      : chunked_mag_comparator
// Description : Sequential magnitude comparator. Two WIDTH-bit operands are
//               compared CHUNK bits per cycle, most significant chunk first,
//               and the compare stops at the first chunk that differs.
//               Supports signed/unsigned mode per operation and a
//               start/busy/done handshake with abort.
// Revision    : 1.0 - initial release
// ============================================================================
module chunked_mag_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 signed_mode,
    input  logic [WIDTH-1:0]                     a,
    input  logic [WIDTH-1:0]                     b,
    input  logic                                 abort,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 gt,
    output logic                                 lt,
    output logic                                 eq,
    output logic [$clog2(WIDTH/CHUNK):0]         cycles
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(NCHUNK) + 1;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] C_TOP_IDX = IW'(NCHUNK - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              gt_q, gt_d;
    logic              lt_q, lt_d;
    logic              eq_q, eq_d;
    logic [CW-1:0]     cycles_q, cycles_d;

    // Flipping the MSB maps two's-complement onto offset binary, so the
    // chunk datapath only ever needs an unsigned compare.
    logic [WIDTH-1:0]  w_msb_flip;
    logic [31:0]       w_base;
    logic [CHUNK-1:0]  w_a_chunk;
    logic [CHUNK-1:0]  w_b_chunk;
    logic [CW-1:0]     w_cycles_now;

    assign w_msb_flip   = WIDTH'(signed_mode) << (WIDTH - 1);
    assign w_base       = 32'(idx_q) * 32'(CHUNK);
    assign w_a_chunk    = a_q[w_base +: CHUNK];
    assign w_b_chunk    = b_q[w_base +: CHUNK];
    // Chunks examined so far including the current one.
    assign w_cycles_now = CW'(NCHUNK) - CW'(idx_q);

    // Next-state logic: operand capture, chunk walk, completion and abort.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        gt_d     = gt_q;
        lt_d     = lt_q;
        eq_d     = eq_q;
        cycles_d = cycles_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    a_d     = a ^ w_msb_flip;
                    b_d     = b ^ w_msb_flip;
                    idx_d   = C_TOP_IDX;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    // Cancelled: no result update and no done pulse.
                    busy_d  = 1'b0;
                    idx_d   = C_TOP_IDX;
                    state_d = S_IDLE;
                end else if (w_a_chunk != w_b_chunk || idx_q == '0) begin
                    gt_d     = (w_a_chunk > w_b_chunk);
                    lt_d     = (w_a_chunk < w_b_chunk);
                    eq_d     = (w_a_chunk == w_b_chunk);
                    cycles_d = w_cycles_now;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    idx_d    = C_TOP_IDX;
                    state_d  = S_IDLE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                idx_d   = C_TOP_IDX;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= C_TOP_IDX;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            cycles_q <= cycles_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign gt     = gt_q;
    assign lt     = lt_q;
    assign eq     = eq_q;
    assign cycles = cycles_q;

endmodule
`default_nettype wire
